cm_sketch_arb: RTL and testbench

CM_SKETCH_ARB -- requirements
Module: cm_sketch_arb

---
 rtl/cm_sketch_arb.sv | 141 ++++++++++++++
 tb/tb_cm_sketch_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cm_sketch_arb.sv
// Two-channel round-robin front end for a count-min sketch: arbitrates requests,
// paces issue with a gap counter, and routes in-order sketch responses back by tag.
module cm_sketch_arb #(
   parameter int ADDR_SIZE = 28,
   parameter int CNT_SIZE  = 32,
   parameter int ISSUE_GAP = 1,
   parameter int TAG_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ch0_req_valid,
   output logic                           ch0_req_ready,
   input  logic [ADDR_SIZE-1:0]           ch0_req_addr,
   input  logic                           ch1_req_valid,
   output logic                           ch1_req_ready,
   input  logic [ADDR_SIZE-1:0]           ch1_req_addr,
   output logic                           sk_input_valid,
   output logic [ADDR_SIZE-1:0]           sk_input_addr,
   input  logic                           sk_output_valid,
   input  logic [ADDR_SIZE-1:0]           sk_output_addr,
   input  logic [CNT_SIZE-1:0]            sk_output_cnt,
   output logic                           ch0_rsp_valid,
   output logic [ADDR_SIZE-1:0]           ch0_rsp_addr,
   output logic [CNT_SIZE-1:0]            ch0_rsp_cnt,
   output logic                           ch1_rsp_valid,
   output logic [ADDR_SIZE-1:0]           ch1_rsp_addr,
   output logic [CNT_SIZE-1:0]            ch1_rsp_cnt,
   output logic [$clog2(TAG_DEPTH+1)-1:0] inflight,
   output logic                           err_orphan
);

   localparam int GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
   localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CW = $clog2(TAG_DEPTH + 1);

   typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} ch_e;

   logic [GW-1:0] r_gap;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   ch_e           r_last;
   ch_e           r_tags [TAG_DEPTH];

   logic w_full;
   logic w_empty;
   logic w_can_issue;
   logic w_pick0;
   logic w_pick1;
   logic w_hs0;
   logic w_hs1;
   logic w_push;
   logic w_pop;
   ch_e  w_head;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Ready is gated by rst so no grant can leak out while reset is held.
   always_comb begin
      w_full        = (r_count == CW'(TAG_DEPTH));
      w_empty       = (r_count == '0);
      w_can_issue   = !rst && (r_gap == '0) && !w_full;
      w_pick0       = ch0_req_valid && (!ch1_req_valid || (r_last == CH1));
      w_pick1       = ch1_req_valid && (!ch0_req_valid || (r_last == CH0));
      ch0_req_ready = w_can_issue && w_pick0;
      ch1_req_ready = w_can_issue && w_pick1;
      w_hs0         = ch0_req_valid && ch0_req_ready;
      w_hs1         = ch1_req_valid && ch1_req_ready;
      w_push        = w_hs0 || w_hs1;
      w_pop         = sk_output_valid && !w_empty;
      w_head        = r_tags[r_rd_ptr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sk_input_valid <= 1'b0;
         sk_input_addr  <= '0;
         r_gap          <= '0;
         r_last         <= CH1;
      end else begin
         sk_input_valid <= w_push;
         if (w_push) begin
            sk_input_addr <= w_hs0 ? ch0_req_addr : ch1_req_addr;
            r_last        <= w_hs0 ? CH0 : CH1;
            r_gap         <= GW'(ISSUE_GAP);
         end else if (r_gap != '0) begin
            r_gap <= r_gap - GW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Tag storage needs no reset: occupancy and pointers define what is live.
   always_ff @(posedge clk) begin
      if (w_push) r_tags[r_wr_ptr] <= w_hs0 ? CH0 : CH1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch0_rsp_valid <= 1'b0;
         ch0_rsp_addr  <= '0;
         ch0_rsp_cnt   <= '0;
         ch1_rsp_valid <= 1'b0;
         ch1_rsp_addr  <= '0;
         ch1_rsp_cnt   <= '0;
         err_orphan    <= 1'b0;
      end else begin
         ch0_rsp_valid <= w_pop && (w_head == CH0);
         ch1_rsp_valid <= w_pop && (w_head == CH1);
         if (w_pop && (w_head == CH0)) begin
            ch0_rsp_addr <= sk_output_addr;
            ch0_rsp_cnt  <= sk_output_cnt;
         end
         if (w_pop && (w_head == CH1)) begin
            ch1_rsp_addr <= sk_output_addr;
            ch1_rsp_cnt  <= sk_output_cnt;
         end
         if (sk_output_valid && w_empty) err_orphan <= 1'b1;
      end
   end

   assign inflight = r_count;

endmodule

// File: tb/tb_cm_sketch_arb.sv
// Scoreboard bench for cm_sketch_arb: a queue-level arbiter/tag model predicts grants and
// responses; a separate monitor pops expectations whenever the DUT presents an output.
module tb_cm_sketch_arb;

   localparam int AW    = 28;
   localparam int CNTW  = 32;
   localparam int GAP   = 1;
   localparam int DEPTH = 8;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [CNTW-1:0] cnt;
      int              due;
   } exp_t;

   typedef struct {
      logic [AW-1:0] a;
      int            c;
   } seen_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main DUT stimulus/outputs
   logic            ch0_req_valid, ch1_req_valid, ch0_req_ready, ch1_req_ready;
   logic [AW-1:0]   ch0_req_addr, ch1_req_addr;
   logic            sk_input_valid, sk_output_valid;
   logic [AW-1:0]   sk_input_addr, sk_output_addr;
   logic [CNTW-1:0] sk_output_cnt;
   logic            ch0_rsp_valid, ch1_rsp_valid, err_orphan;
   logic [AW-1:0]   ch0_rsp_addr, ch1_rsp_addr;
   logic [CNTW-1:0] ch0_rsp_cnt, ch1_rsp_cnt;
   logic [$clog2(DEPTH+1)-1:0] inflight;

   cm_sketch_arb #(.ADDR_SIZE(AW), .CNT_SIZE(CNTW), .ISSUE_GAP(GAP), .TAG_DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst),
      .ch0_req_valid(ch0_req_valid), .ch0_req_ready(ch0_req_ready), .ch0_req_addr(ch0_req_addr),
      .ch1_req_valid(ch1_req_valid), .ch1_req_ready(ch1_req_ready), .ch1_req_addr(ch1_req_addr),
      .sk_input_valid(sk_input_valid), .sk_input_addr(sk_input_addr),
      .sk_output_valid(sk_output_valid), .sk_output_addr(sk_output_addr), .sk_output_cnt(sk_output_cnt),
      .ch0_rsp_valid(ch0_rsp_valid), .ch0_rsp_addr(ch0_rsp_addr), .ch0_rsp_cnt(ch0_rsp_cnt),
      .ch1_rsp_valid(ch1_rsp_valid), .ch1_rsp_addr(ch1_rsp_addr), .ch1_rsp_cnt(ch1_rsp_cnt),
      .inflight(inflight), .err_orphan(err_orphan)
   );

   // second instance: zero issue gap, sketch looped back with one cycle of latency
   logic            d0_v0 = 1'b0, d0_v1 = 1'b0, d0_r0, d0_r1, d0_iv, d0_rv0, d0_rv1, d0_err;
   logic [AW-1:0]   d0_a0 = '0, d0_a1 = 28'd111, d0_ia, d0_ra0, d0_ra1;
   logic [CNTW-1:0] d0_rc0, d0_rc1;
   logic [2:0]      d0_inflight;

   cm_sketch_arb #(.ADDR_SIZE(AW), .CNT_SIZE(CNTW), .ISSUE_GAP(0), .TAG_DEPTH(4)) u_dut0 (
      .clk(clk), .rst(rst),
      .ch0_req_valid(d0_v0), .ch0_req_ready(d0_r0), .ch0_req_addr(d0_a0),
      .ch1_req_valid(d0_v1), .ch1_req_ready(d0_r1), .ch1_req_addr(d0_a1),
      .sk_input_valid(d0_iv), .sk_input_addr(d0_ia),
      .sk_output_valid(d0_iv), .sk_output_addr(d0_ia), .sk_output_cnt(32'd5),
      .ch0_rsp_valid(d0_rv0), .ch0_rsp_addr(d0_ra0), .ch0_rsp_cnt(d0_rc0),
      .ch1_rsp_valid(d0_rv1), .ch1_rsp_addr(d0_ra1), .ch1_rsp_cnt(d0_rc1),
      .inflight(d0_inflight), .err_orphan(d0_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string n, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   // reference model state
   int   mtags[$];
   int   mgap  = 0;
   int   mlast = 1;
   bit   merr  = 1'b0;
   exp_t exp_q[3][$];          // 0: sketch issue, 1: ch0 response, 2: ch1 response
   seen_t seen[$];
   logic [AW-1:0] sk_q[$];     // tb-side sketch: addresses awaiting a response

   // stimulus controls
   logic          rst_v = 1'b1;
   logic          v0 = 1'b0, v1 = 1'b0;
   logic [AW-1:0] a0 = '0, a1 = '0;
   int            sk_mode = 0; // 0 withhold, 1 random, 2 respond whenever possible
   bit            one_shot = 1'b0, force_orphan = 1'b0, hs_any = 1'b0;

   function automatic logic [CNTW-1:0] sk_cnt(input logic [AW-1:0] a);
      if (a == 28'd105) return 32'd1;
      if (a == 28'd108) return 32'd3;
      return CNTW'($urandom);
   endfunction

   task automatic step();
      exp_t e;
      bit   can, g0, g1, r0, r1, ov;
      int   ch;
      logic [AW-1:0]   oa;
      logic [CNTW-1:0] oc;
      @(negedge clk);
      rst = rst_v;
      ov = 1'b0; oa = '0; oc = '0;
      if (rst_v) sk_q.delete();
      else if (force_orphan) begin
         ov = 1'b1; oa = 28'd300; oc = 32'd9;
      end else if (sk_q.size() > 0 &&
                   (sk_mode == 2 || one_shot || (sk_mode == 1 && $urandom_range(0, 2) != 0))) begin
         oa = sk_q.pop_front(); oc = sk_cnt(oa); ov = 1'b1;
      end
      if (!rst_v && sk_input_valid) sk_q.push_back(sk_input_addr);
      sk_output_valid = ov; sk_output_addr = oa; sk_output_cnt = oc;
      ch0_req_valid = v0; ch0_req_addr = a0; ch1_req_valid = v1; ch1_req_addr = a1;
      #1;
      if (rst_v) begin
         mtags.delete(); mgap = 0; mlast = 1; merr = 1'b0;
         for (int k = 0; k < 3; k++) exp_q[k].delete();
         chk("rst_sk_input", {sk_input_valid, sk_input_addr}, 0);
         chk("rst_rsp0", {ch0_rsp_valid, ch0_rsp_addr, ch0_rsp_cnt}, 0);
         chk("rst_rsp1", {ch1_rsp_valid, ch1_rsp_addr, ch1_rsp_cnt}, 0);
      end
      can = !rst_v && mgap == 0 && mtags.size() < DEPTH;
      g0  = v0 && (!v1 || mlast == 1);
      g1  = v1 && (!v0 || mlast == 0);
      r0  = can && g0;
      r1  = can && g1;
      chk("ch0_req_ready", ch0_req_ready, r0);
      chk("ch1_req_ready", ch1_req_ready, r1);
      chk("inflight", inflight, mtags.size());
      chk("err_orphan", err_orphan, merr);
      hs_any = 1'b0;
      if (!rst_v) begin
         if (ov) begin
            if (mtags.size() > 0) begin
               ch = mtags.pop_front();
               e.addr = oa; e.cnt = oc; e.due = cyc + 1;
               exp_q[1 + ch].push_back(e);
            end else merr = 1'b1;
         end
         if (r0 || r1) begin
            ch = r0 ? 0 : 1;
            mtags.push_back(ch);
            e.addr = r0 ? a0 : a1; e.cnt = '0; e.due = cyc + 1;
            exp_q[0].push_back(e);
            mlast = ch; mgap = GAP; hs_any = 1'b1;
         end else if (mgap > 0) mgap--;
      end
   endtask

   task automatic drain();
      v0 = 1'b0; v1 = 1'b0; sk_mode = 2;
      for (int n = 0; n < 100 && mtags.size() > 0; n++) step();
      step();
      chk("drain_inflight", inflight, 0);
   endtask

   // monitor: pops the matching expectation whenever an output is presented
   task automatic mon_port(input int k, input string nm, input logic v,
                           input logic [AW-1:0] a, input logic [CNTW-1:0] c);
      exp_t e;
      if (v) begin
         if (exp_q[k].size() == 0) chk({nm, "_unexpected"}, v, 0);
         else begin
            e = exp_q[k].pop_front();
            chk({nm, "_addr"}, a, e.addr);
            if (k > 0) chk({nm, "_cnt"}, c, e.cnt);
            chk({nm, "_cycle"}, cyc, e.due);
         end
      end else if (exp_q[k].size() > 0 && exp_q[k][0].due <= cyc) begin
         e = exp_q[k].pop_front();
         chk({nm, "_missing"}, v, 1);
      end
   endtask

   initial begin
      seen_t s;
      forever begin
         @(posedge clk);
         #1;
         if (sk_input_valid) begin
            s.a = sk_input_addr; s.c = cyc;
            seen.push_back(s);
         end
         mon_port(0, "issue", sk_input_valid, sk_input_addr, '0);
         mon_port(1, "rsp0", ch0_rsp_valid, ch0_rsp_addr, ch0_rsp_cnt);
         mon_port(2, "rsp1", ch1_rsp_valid, ch1_rsp_addr, ch1_rsp_cnt);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] want[4];
      want[0] = 28'd107; want[1] = 28'd106; want[2] = 28'd107; want[3] = 28'd106;
      ch0_req_valid = 1'b0; ch1_req_valid = 1'b0; ch0_req_addr = '0; ch1_req_addr = '0;
      sk_output_valid = 1'b0; sk_output_addr = '0; sk_output_cnt = '0;

      // reset with both channels requesting: no grant may appear
      rst_v = 1'b1; v0 = 1'b1; v1 = 1'b1; a0 = 28'd1; a1 = 28'd2;
      repeat (3) step();
      v0 = 1'b0; v1 = 1'b0; rst_v = 1'b0;
      step();

      // zero-gap instance: ch1 alone streams one issue per cycle
      d0_v1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("d0_ch1_ready", d0_r1, 1);
         chk("d0_ch0_ready", d0_r0, 0);
         if (i >= 2) begin
            chk("d0_sk_input", {d0_iv, d0_ia}, {1'b1, 28'd111});
            chk("d0_inflight", d0_inflight, 1);
            chk("d0_rsp1", {d0_rv1, d0_ra1, d0_rc1}, {1'b1, 28'd111, 32'd5});
            chk("d0_rsp0_valid", d0_rv0, 0);
         end
      end
      d0_v1 = 1'b0;

      // contention at gap 1: alternate 107/106 every other cycle starting with ch0
      seen.delete();
      v0 = 1'b1; a0 = 28'd107; v1 = 1'b1; a1 = 28'd106; sk_mode = 2;
      repeat (12) step();
      chk("rr_seen_count", seen.size() >= 4, 1);
      if (seen.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("rr_seq_addr", seen[i].a, want[i]);
            if (i > 0) chk("rr_seq_spacing", seen[i].c - seen[i-1].c, 2);
         end
      end
      drain();

      // fill the tag FIFO with responses withheld
      v0 = 1'b1; a0 = 28'd200; v1 = 1'b1; a1 = 28'd201; sk_mode = 0;
      repeat (20) step();
      chk("full_inflight", inflight, DEPTH);
      chk("full_ready", {ch0_req_ready, ch1_req_ready}, 0);
      one_shot = 1'b1;
      step();
      one_shot = 1'b0;
      chk("full_pop_blocks", ch0_req_ready | ch1_req_ready, 0);
      step();
      chk("resume_inflight", inflight, DEPTH - 1);
      chk("resume_ready", ch0_req_ready | ch1_req_ready, 1);
      drain();

      // ch0 105 then ch1 108; responses carry counts 1 and 3
      sk_mode = 0; v0 = 1'b1; a0 = 28'd105;
      hs_any = 1'b0;
      for (int n = 0; n < 10 && !hs_any; n++) step();
      v0 = 1'b0; v1 = 1'b1; a1 = 28'd108;
      hs_any = 1'b0;
      for (int n = 0; n < 10 && !hs_any; n++) step();
      v1 = 1'b0;
      repeat (2) step();
      drain();

      // randomized traffic with random sketch latency
      sk_mode = 1;
      for (int i = 0; i < 400; i++) begin
         v0 = ($urandom_range(0, 9) < 7);
         v1 = ($urandom_range(0, 9) < 7);
         a0 = AW'($urandom);
         a1 = AW'($urandom);
         step();
      end
      drain();

      // orphan response: sticky until reset
      chk("orphan_pre", err_orphan, 0);
      force_orphan = 1'b1;
      step();
      force_orphan = 1'b0;
      repeat (5) step();
      chk("orphan_sticky", err_orphan, 1);
      rst_v = 1'b1; step();
      rst_v = 1'b0; step();
      chk("orphan_cleared", err_orphan, 0);

      // reset mid-flight discards tags; a stale response becomes an orphan
      v0 = 1'b1; a0 = 28'd300; sk_mode = 0;
      repeat (5) step();
      v0 = 1'b0;
      step();
      chk("midrst_inflight_pre", inflight, 3);
      rst_v = 1'b1; step();
      rst_v = 1'b0; step();
      chk("midrst_inflight", inflight, 0);
      force_orphan = 1'b1;
      step();
      force_orphan = 1'b0;
      repeat (2) step();
      chk("midrst_orphan", err_orphan, 1);

      repeat (3) step();
      for (int k = 0; k < 3; k++) chk("leftover_expected", exp_q[k].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
